// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) before the stop bit.
module uart_rx #(
  parameter int unsigned DIV        = 434,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frm_err,
  output logic       o_overrun,
  output logic       o_par_err
);

  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
`endif

  logic             rxd_meta;
  logic             rxd_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             half_done_c;
  logic             bit_done_c;
  logic             deliver_c;
  logic             frm_err_c;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             par_bad_c;
  logic             par_err_c;
`endif

  // Two-flop synchronizer; idle-high reset keeps a reset from looking like a start bit
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= i_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign half_done_c = (cnt_q == CNT_W'(HALF - 1));
  assign bit_done_c  = (cnt_q == CNT_W'(DIV - 1));
`ifdef UART_RX_PARITY_EN
  assign par_bad_c   = par_bit_q ^ (^shift_q) ^ 1'(PARITY_ODD);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    deliver_c = 1'b0;
    frm_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    par_err_c = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (half_done_c) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (bit_done_c) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          idx_d   = idx_q + IDX_W'(1);
`ifdef UART_RX_PARITY_EN
          if (idx_q == IDX_W'(7)) state_d = S_PARITY;
`else
          if (idx_q == IDX_W'(7)) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_done_c) begin
          cnt_d     = '0;
          par_bit_d = rxd_s;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Return to IDLE on the sample cycle so a back-to-back start edge is not missed
        if (bit_done_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rxd_s) begin
            frm_err_c = 1'b1;
            state_d   = S_WAIT_HI;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_c) begin
            par_err_c = 1'b1;
`endif
          end else begin
            deliver_c = 1'b1;
          end
        end
      end
      S_WAIT_HI: begin
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Holding register: a same-cycle accept frees the slot for the new byte
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_frm_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_frm_err <= frm_err_c;
      o_overrun <= deliver_c & o_valid & ~i_ready;
      if (deliver_c && (!o_valid || i_ready)) begin
        o_data  <= shift_q;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      par_bit_q <= 1'b0;
      o_par_err <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      o_par_err <= par_err_c;
    end
  end
`else
  logic unused_par_cfg;
  assign unused_par_cfg = 1'(PARITY_ODD);
  assign o_par_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=5; compile with UART_RX_PARITY_EN to also cover the parity bit.
module tb_uart_rx;

  localparam int unsigned DIV = 5;
  localparam int unsigned H   = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Negedge-count distance from the pin start-bit drive cycle to the o_valid cycle
  localparam int LAT = 2 + H + (NB - 1) * DIV + 1;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_rxd = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frm_err;
  logic       o_overrun;
  logic       o_par_err;

  int total = 0;
  int bad = 0;

  int         cyc = 0;
  logic       v_prev = 1'b0;
  logic [7:0] q_data[$];
  int         q_cyc[$];
  int         n_fall = 0;
  int         n_frm = 0;
  int         n_ovr = 0;
  int         n_par = 0;
  int         frm_cyc = 0;
  int         ovr_cyc = 0;

  always #5 clk = ~clk;

  uart_rx #(.DIV(DIV), .PARITY_ODD(0)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_rxd    (i_rxd),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_frm_err(o_frm_err),
    .o_overrun(o_overrun),
    .o_par_err(o_par_err)
  );

  // Mid-cycle event log of DUT outputs
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_valid && !v_prev) begin
      q_data.push_back(o_data);
      q_cyc.push_back(cyc);
    end
    if (!o_valid && v_prev) n_fall = n_fall + 1;
    if (o_frm_err) begin n_frm = n_frm + 1; frm_cyc = cyc; end
    if (o_overrun) begin n_ovr = n_ovr + 1; ovr_cyc = cyc; end
    if (o_par_err) n_par = n_par + 1;
    v_prev = o_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_data.delete();
    q_cyc.delete();
    n_fall = 0; n_frm = 0; n_ovr = 0; n_par = 0;
    frm_cyc = 0; ovr_cyc = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    logic [10:0] fr;
    fr       = '1;
    fr[0]    = 1'b0;
    fr[8:1]  = b;
    fr[9]    = (^b) ^ par_flip;
    fr[NB-1] = stop_bit;
    for (int i = 0; i < NB; i++) begin
      i_rxd = fr[i];
      repeat (DIV) step();
    end
  endtask

  function automatic logic [7:0] data_at(input int idx);
    return (q_data.size() > idx) ? q_data[idx] : 8'hxx;
  endfunction

  function automatic int cyc_at(input int idx);
    return (q_cyc.size() > idx) ? q_cyc[idx] : -1;
  endfunction

  task automatic test_reset();
    i_rst = 1'b0; i_rxd = 1'b1; i_ready = 1'b0;
    repeat (3) step();
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", o_data); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++; if (o_frm_err !== 1'b0) begin bad++; $display("FAIL reset_frm got=%b want=0", o_frm_err); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", o_overrun); end
    total++; if (o_par_err !== 1'b0) begin bad++; $display("FAIL reset_par got=%b want=0", o_par_err); end
    i_rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    int s;
    i_ready = 1'b1;
    clear_log();
    s = cyc;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    repeat (10) step();
    total++; if (q_data.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", q_data.size()); end
    total++; if (data_at(0) !== 8'h55) begin bad++; $display("FAIL b2b_data0 got=%h want=55", data_at(0)); end
    total++; if (data_at(1) !== 8'hA3) begin bad++; $display("FAIL b2b_data1 got=%h want=a3", data_at(1)); end
    total++; if (cyc_at(0) !== s + 1 + LAT) begin bad++; $display("FAIL b2b_lat0 got=%0d want=%0d", cyc_at(0), s + 1 + LAT); end
    total++; if (cyc_at(1) !== s + 1 + LAT + NB * DIV) begin bad++; $display("FAIL b2b_lat1 got=%0d want=%0d", cyc_at(1), s + 1 + LAT + NB * DIV); end
    total++; if (n_frm + n_ovr + n_par !== 0) begin bad++; $display("FAIL b2b_errs got=%0d want=0", n_frm + n_ovr + n_par); end
    total++; if (n_fall !== 2) begin bad++; $display("FAIL b2b_falls got=%0d want=2", n_fall); end
  endtask

  task automatic test_glitch();
    int s;
    clear_log();
    i_rxd = 1'b0;
    repeat (2) step();
    i_rxd = 1'b1;
    repeat (20) step();
    total++; if (q_data.size() !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", q_data.size()); end
    total++; if (n_frm + n_ovr + n_par !== 0) begin bad++; $display("FAIL glitch_errs got=%0d want=0", n_frm + n_ovr + n_par); end
    s = cyc;
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (5) step();
    total++; if (data_at(0) !== 8'h81) begin bad++; $display("FAIL glitch_next_data got=%h want=81", data_at(0)); end
    total++; if (cyc_at(0) !== s + 1 + LAT) begin bad++; $display("FAIL glitch_next_lat got=%0d want=%0d", cyc_at(0), s + 1 + LAT); end
  endtask

  task automatic test_framing();
    int s;
    clear_log();
    s = cyc;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (30) step();
    total++; if (n_frm !== 1) begin bad++; $display("FAIL frm_count got=%0d want=1", n_frm); end
    total++; if (frm_cyc !== s + 1 + LAT) begin bad++; $display("FAIL frm_cycle got=%0d want=%0d", frm_cyc, s + 1 + LAT); end
    total++; if (q_data.size() !== 0) begin bad++; $display("FAIL frm_valid got=%0d want=0", q_data.size()); end
    i_rxd = 1'b1;
    repeat (3) step();
    s = cyc;
    send_frame(8'h7E, 1'b1, 1'b0);
    repeat (5) step();
    total++; if (q_data.size() !== 1) begin bad++; $display("FAIL frm_next_count got=%0d want=1", q_data.size()); end
    total++; if (data_at(0) !== 8'h7E) begin bad++; $display("FAIL frm_next_data got=%h want=7e", data_at(0)); end
    total++; if (cyc_at(0) !== s + 1 + LAT) begin bad++; $display("FAIL frm_next_lat got=%0d want=%0d", cyc_at(0), s + 1 + LAT); end
    total++; if (n_frm !== 1) begin bad++; $display("FAIL frm_retrigger got=%0d want=1", n_frm); end
  endtask

  task automatic test_overrun();
    int s;
    i_ready = 1'b0;
    clear_log();
    s = cyc;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (5) step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", o_valid); end
    total++; if (o_data !== 8'h11) begin bad++; $display("FAIL ovr_held got=%h want=11", o_data); end
    total++; if (n_ovr !== 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", n_ovr); end
    total++; if (ovr_cyc !== s + 1 + LAT + NB * DIV) begin bad++; $display("FAIL ovr_cycle got=%0d want=%0d", ovr_cyc, s + 1 + LAT + NB * DIV); end
    total++; if (n_frm + n_par !== 0) begin bad++; $display("FAIL ovr_errs got=%0d want=0", n_frm + n_par); end
    i_ready = 1'b1;
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b want=0", o_valid); end
    i_ready = 1'b0;
    step();
  endtask

  task automatic test_reload();
    int s;
    int s2;
    i_ready = 1'b0;
    clear_log();
    s  = cyc;
    s2 = s + NB * DIV;
    fork
      begin
        send_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h99, 1'b1, 1'b0);
      end
      begin
        while (cyc < s2 + LAT - 1) step();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
      end
    join
    repeat (5) step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL reload_valid got=%b want=1", o_valid); end
    total++; if (o_data !== 8'h99) begin bad++; $display("FAIL reload_data got=%h want=99", o_data); end
    total++; if (n_ovr !== 0) begin bad++; $display("FAIL reload_ovr got=%0d want=0", n_ovr); end
    total++; if (n_fall !== 0) begin bad++; $display("FAIL reload_fall got=%0d want=0", n_fall); end
    total++; if (data_at(0) !== 8'h44) begin bad++; $display("FAIL reload_first got=%h want=44", data_at(0)); end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reload_drain got=%b want=0", o_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int s;
    i_ready = 1'b0;
    clear_log();
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (3) step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rmid_held got=%b want=1", o_valid); end
    b = 8'hB6;
    i_rxd = 1'b0;
    repeat (DIV) step();
    for (int k = 0; k < 4; k++) begin
      i_rxd = b[k];
      repeat (DIV) step();
    end
    i_rxd = b[4];
    repeat (2) step();
    i_rst = 1'b0;
    i_rxd = 1'b1;
    repeat (2) step();
    i_rst = 1'b1;
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", o_valid); end
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", o_data); end
    total++; if ({o_frm_err, o_overrun, o_par_err} !== 3'b000) begin bad++; $display("FAIL rmid_errs got=%b want=000", {o_frm_err, o_overrun, o_par_err}); end
    i_ready = 1'b1;
    clear_log();
    s = cyc;
    send_frame(8'hF0, 1'b1, 1'b0);
    repeat (5) step();
    total++; if (data_at(0) !== 8'hF0) begin bad++; $display("FAIL rmid_next_data got=%h want=f0", data_at(0)); end
    total++; if (cyc_at(0) !== s + 1 + LAT) begin bad++; $display("FAIL rmid_next_lat got=%0d want=%0d", cyc_at(0), s + 1 + LAT); end
    total++; if (n_frm + n_ovr + n_par !== 0) begin bad++; $display("FAIL rmid_next_errs got=%0d want=0", n_frm + n_ovr + n_par); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    i_ready = 1'b1;
    clear_log();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (5) step();
    total++; if (data_at(0) !== 8'h07) begin bad++; $display("FAIL par_good_data got=%h want=07", data_at(0)); end
    total++; if (n_par !== 0) begin bad++; $display("FAIL par_good_err got=%0d want=0", n_par); end
    clear_log();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (5) step();
    total++; if (q_data.size() !== 0) begin bad++; $display("FAIL par_bad_valid got=%0d want=0", q_data.size()); end
    total++; if (n_par !== 1) begin bad++; $display("FAIL par_bad_err got=%0d want=1", n_par); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reload();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
